// File: rtl/dino_jump_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dino_jump_ctrl
//  Description : Jump physics controller for a side-scrolling runner sprite.
//                Synchronises the jump button, detects presses, and steps a
//                GROUND/RISE/FALL trajectory once per video frame. It also
//                counts completed landings.
//  Revision    : 1.0 - initial release
// ============================================================================
module dino_jump_ctrl #(
    parameter logic [9:0] GROUND_Y = 10'd400,
    parameter logic [9:0] X_POS    = 10'd80,
    parameter logic [5:0] V0       = 6'd16,
    parameter logic [5:0] GRAVITY  = 6'd1,
    parameter logic [5:0] VMAX     = 6'd16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       jump_btn,
    input  logic       freeze,
    output logic [9:0] x_desired,
    output logic [9:0] y_desired,
    output logic       airborne,
    output logic [7:0] jump_count
);

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_RISE   = 2'd1,
        ST_FALL   = 2'd2
    } state_t;

    localparam logic [1:0] c_SETTLED = 2'd2;

    // Button synchroniser and edge detector state
    logic        r_sync1;
    logic        r_sync2;
    logic        r_btn_prev;
    logic [1:0]  r_settle_cnt;

    // Jump state
    state_t      r_state;
    logic        r_pending;
    logic [5:0]  r_vel;
    logic [9:0]  r_y;
    logic        r_airborne;
    logic [7:0]  r_jump_count;

    // Combinational helpers
    logic        w_settled;
    logic        w_btn_edge;
    logic        w_step;
    logic [9:0]  w_rise_y;
    logic        w_rise_done;
    logic [6:0]  w_fall_sum;
    logic [5:0]  w_fall_vn;
    logic [10:0] w_fall_ysum;
    logic        w_fall_land;

    // The synchroniser holds zeros out of reset, so for two clocks its output
    // does not reflect the real button. Edges are ignored until it has filled.
    // r_btn_prev is held high until then, so a button held through reset
    // looks like "already pressed" rather than a fresh press.
    assign w_settled  = (r_settle_cnt == c_SETTLED);
    assign w_btn_edge = w_settled & r_sync2 & ~r_btn_prev;

    // Physics only advances on an unfrozen frame tick
    assign w_step = frame_tick & ~freeze;

    // Rising: move up by vel, never above row 0. Apex is reached once the
    // velocity can no longer absorb a full gravity step.
    assign w_rise_y    = ({4'd0, r_vel} > r_y) ? 10'd0 : (r_y - {4'd0, r_vel});
    assign w_rise_done = (r_vel <= GRAVITY);

    // Falling: accelerate up to the terminal velocity. The landing test is
    // done one bit wider so a large step near the bottom cannot wrap.
    assign w_fall_sum  = {1'b0, r_vel} + {1'b0, GRAVITY};
    assign w_fall_vn   = (w_fall_sum > {1'b0, VMAX}) ? VMAX : w_fall_sum[5:0];
    assign w_fall_ysum = {1'b0, r_y} + {5'd0, w_fall_vn};
    assign w_fall_land = (w_fall_ysum >= {1'b0, GROUND_Y});

    // Two-flop button synchroniser, settle counter and edge history
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_btn_prev   <= 1'b1;
            r_settle_cnt <= 2'd0;
        end else begin
            r_sync1    <= jump_btn;
            r_sync2    <= r_sync1;
            r_btn_prev <= w_settled ? r_sync2 : 1'b1;
            if (!w_settled) begin
                r_settle_cnt <= r_settle_cnt + 2'd1;
            end
        end
    end

    // Jump FSM: state, velocity, height, airborne flag, pending press, landings
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_GROUND;
            r_pending    <= 1'b0;
            r_vel        <= 6'd0;
            r_y          <= GROUND_Y;
            r_airborne   <= 1'b0;
            r_jump_count <= 8'd0;
        end else if (freeze) begin
            // Game over: everything holds, and any press is forgotten
            r_pending <= 1'b0;
        end else begin
            case (r_state)
                ST_GROUND: begin
                    if (w_step && (r_pending || w_btn_edge)) begin
                        // Launch; a press in this very cycle counts too
                        r_state    <= ST_RISE;
                        r_vel      <= V0;
                        r_y        <= GROUND_Y;
                        r_airborne <= 1'b1;
                        r_pending  <= 1'b0;
                    end else if (w_btn_edge) begin
                        r_pending <= 1'b1;
                    end
                end
                ST_RISE: begin
                    // Presses while in the air are dropped (no double jump)
                    r_pending <= 1'b0;
                    if (w_step) begin
                        r_y <= w_rise_y;
                        if (w_rise_done) begin
                            r_vel   <= 6'd0;
                            r_state <= ST_FALL;
                        end else begin
                            r_vel <= r_vel - GRAVITY;
                        end
                    end
                end
                ST_FALL: begin
                    r_pending <= 1'b0;
                    if (w_step) begin
                        if (w_fall_land) begin
                            r_y        <= GROUND_Y;
                            r_vel      <= 6'd0;
                            r_state    <= ST_GROUND;
                            r_airborne <= 1'b0;
                            if (r_jump_count != 8'hFF) begin
                                r_jump_count <= r_jump_count + 8'd1;
                            end
                        end else begin
                            r_y   <= w_fall_ysum[9:0];
                            r_vel <= w_fall_vn;
                        end
                    end
                end
                default: begin
                    r_state    <= ST_GROUND;
                    r_vel      <= 6'd0;
                    r_y        <= GROUND_Y;
                    r_airborne <= 1'b0;
                    r_pending  <= 1'b0;
                end
            endcase
        end
    end

    assign x_desired  = X_POS;
    assign y_desired  = r_y;
    assign airborne   = r_airborne;
    assign jump_count = r_jump_count;

endmodule
`default_nettype wire

// File: doc/dino_jump_ctrl.md
DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 SHALL have parameter GROUND_Y, default 10'd400: sprite top-row y when the sprite is on the ground.
REQ-002 SHALL have parameter X_POS, default 10'd80: fixed sprite x position.
REQ-003 SHALL have parameter V0, default 6'd16: initial upward velocity in pixels/frame.
REQ-004 SHALL have parameter GRAVITY, default 6'd1: velocity change per frame.
REQ-005 SHALL have parameter VMAX, default 6'd16: fall-velocity ceiling.
REQ-006 SHALL have port clk  input  1: the single clock; all flops are on its rising edge.
REQ-007 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-008 SHALL have port frame_tick  input  1: one-cycle pulse per video frame, synchronous to clk.
REQ-009 SHALL have port jump_btn  input  1: raw asynchronous push-button level, active-high.
REQ-010 SHALL have port freeze  input  1: game-over hold, synchronous level.
REQ-011 SHALL have port x_desired  output  10: sprite x, driven constant X_POS.
REQ-012 SHALL have port y_desired  output  10: sprite top-row y.
REQ-013 SHALL have port airborne  output  1: high in RISE or FALL.
REQ-014 SHALL have port jump_count  output  8: completed landings, saturating at 8'hFF.

Function
REQ-015 SHALL pass jump_btn through a 2-flop synchronizer, then detect rising edges (0->1) on the synchronized signal.
REQ-016 SHALL set a pending flag on a detected edge while in GROUND; edges seen in RISE or FALL SHALL be discarded (no double jump).
REQ-017 SHALL implement states GROUND, RISE and FALL, held in registers together with a 6-bit velocity vel and a 10-bit y.
REQ-018 SHALL update state, vel and y only in a cycle where frame_tick=1 and freeze=0; the new values SHALL be visible on the next clock edge (1-cycle latency).
REQ-019 SHALL, in GROUND on a tick with pending=1 (including an edge detected in that same cycle), enter RISE, set vel=V0, leave y=GROUND_Y and clear pending.
REQ-020 SHALL, in RISE on a tick, compute y <= y - vel, clamped to 0 if vel > y; if vel > GRAVITY then vel <= vel - GRAVITY, else vel <= 0 and the state goes to FALL.
REQ-021 SHALL, in FALL on a tick, compute vn = min(vel + GRAVITY, VMAX); if y + vn >= GROUND_Y (compared at 11-bit width), then y <= GROUND_Y, vel <= 0, state -> GROUND and jump_count increments; otherwise y <= y + vn and vel <= vn.
REQ-022 SHALL keep jump_count at 8'hFF once reached; no wrap.
REQ-023 SHALL, while freeze=1, hold state, vel, y and jump_count, ignore ticks, and clear pending every cycle.
REQ-024 SHALL drive airborne and y_desired directly from registers; they SHALL NOT be combinational from the inputs.

Reset
REQ-025 SHALL, while reset=0 (asynchronous), force state=GROUND, vel=0, y_desired=GROUND_Y, jump_count=0, pending=0, airborne=0 and synchronizer flops=0, including mid-jump.
REQ-026 SHALL resume normal operation on the first clock edge after reset returns high; a button held high through reset SHALL NOT produce a jump.

Verification
REQ-027 SHALL test this: defaults, press button, then 32 ticks -> RISE for 16 ticks with apex y=264 (400-136), FALL for 16 ticks landing at y=400 exactly, airborne high for exactly those 32 ticks, jump_count=1.
REQ-028 SHALL test this: second button edge at tick 5 of the jump -> ignored; no jump follows the landing.
REQ-029 SHALL test this: button edge and frame_tick in the same GROUND cycle -> RISE entered, y_desired=384 after the next tick.
REQ-030 SHALL test this: freeze=1 at apex for 10 ticks -> y stays 264; after release the descent resumes and lands at 400.
REQ-031 SHALL test this: reset=0 asserted at tick 20 of a jump -> y_desired=400, airborne=0 and jump_count=0 immediately, without waiting for a clock edge.
REQ-032 SHALL test this: 260 complete jumps -> jump_count=8'hFF.
